// File: rtl/vga_pkg.sv
// vga_pkg: pixel constants, fetch-state encoding and pixel unpack shared by the line buffer
package vga_pkg;
  localparam int PIX_W = 12;
  localparam int PIX_PER_WORD = 2;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT} fetch_state_t;
  function automatic logic [PIX_W-1:0] unpack_pix(input logic [PIX_PER_WORD*PIX_W-1:0] w, input logic half);
    return half ? w[2*PIX_W-1:PIX_W] : w[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/vga_bank_ram.sv
// vga_bank_ram: one-write one-read synchronous RAM holding one line bank
module vga_bank_ram #(
  parameter int DEPTH = 320,
  parameter int W = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_line_buf.sv
// vga_line_buf: ping-pong line buffer fetching frame lines from memory for the VGA timing controller
module vga_line_buf
  import vga_pkg::*;
#(
  parameter int MAX_HPIX = 640,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable_i,
  input  logic [AW-1:0]    base_addr_i,
  input  logic [9:0]       hpixels_i,
  input  logic [9:0]       vlines_i,
  input  logic             frame_start_i,
  output logic             mem_req_o,
  output logic [AW-1:0]    mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [DW-1:0]    mem_rdata_i,
  input  logic             data_req_i,
  output logic [PIX_W-1:0] data_o,
  output logic             underflow_o
);
  localparam int DEPTH = MAX_HPIX / PIX_PER_WORD;
  localparam int IW = $clog2(DEPTH);
  fetch_state_t state;
  logic [9:0] hpix, vlines, lines, ridx, wpl_m1;
  logic [IW-1:0] widx, raddr;
  logic [1:0] full, clr, set, full_nx;
  logic fill_bank, disp_bank, pend, drop, rd_vld, rd_half, rd_bank;
  logic beat, last, done, rd, rend, unused;
  logic [PIX_W-1:0] hold, pix_q;
  logic [2*PIX_W-1:0] wdata;
  logic [2*PIX_W-1:0] q [2];
  assign wpl_m1 = {1'b0, hpix[9:1]} - 10'd1;
  assign beat = pend & mem_rvalid_i;
  assign last = 10'(widx) == wpl_m1;
  assign done = beat & last;
  assign rd = data_req_i & full[disp_bank];
  assign rend = data_req_i & (ridx + 10'd1 == hpix);
  assign clr = rend ? {disp_bank, ~disp_bank} : 2'b00;
  assign set = done ? {fill_bank, ~fill_bank} : 2'b00;
  // a bank emptied by the display in the same cycle it completes a fill ends up full
  assign full_nx = (full & ~clr) | set;
  assign raddr = IW'(ridx >> 1);
  assign wdata = {mem_rdata_i[27:16], mem_rdata_i[11:0]};
  assign pix_q = unpack_pix(q[rd_bank], rd_half);
  assign data_o = rd_vld ? pix_q : hold;
  assign unused = ^{mem_rdata_i[DW-1:28], mem_rdata_i[15:12]};
  for (genvar b = 0; b < 2; b++) begin : g_bank
    vga_bank_ram #(.DEPTH(DEPTH), .W(2*PIX_W)) u_ram (
      .clk(clk),
      .we(beat && !frame_start_i && fill_bank == 1'(b)),
      .waddr(widx),
      .wdata(wdata),
      .re(rd && disp_bank == 1'(b)),
      .raddr(raddr),
      .rdata(q[b])
    );
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      mem_req_o <= 1'b0;
      mem_addr_o <= '0;
      hpix <= '0;
      vlines <= '0;
      lines <= '0;
      ridx <= '0;
      widx <= '0;
      full <= '0;
      fill_bank <= 1'b0;
      disp_bank <= 1'b0;
      pend <= 1'b0;
      drop <= 1'b0;
      rd_vld <= 1'b0;
      rd_half <= 1'b0;
      rd_bank <= 1'b0;
      hold <= '0;
      underflow_o <= 1'b0;
    end else if (frame_start_i) begin
      state <= enable_i ? FETCH : IDLE;
      mem_req_o <= 1'b0;
      mem_addr_o <= base_addr_i;
      hpix <= hpixels_i;
      vlines <= vlines_i;
      lines <= '0;
      ridx <= '0;
      widx <= '0;
      full <= '0;
      fill_bank <= 1'b0;
      disp_bank <= 1'b0;
      pend <= 1'b0;
      drop <= (pend & ~mem_rvalid_i) | (mem_req_o & mem_gnt_i);
      rd_vld <= 1'b0;
      hold <= data_o;
      underflow_o <= 1'b0;
    end else begin
      full <= full_nx;
      if (rd_vld) hold <= pix_q;
      rd_vld <= rd;
      if (data_req_i) begin
        rd_half <= ridx[0];
        rd_bank <= disp_bank;
        ridx <= rend ? 10'd0 : ridx + 10'd1;
        disp_bank <= disp_bank ^ rend;
        if (!full[disp_bank]) begin
          hold <= '0;
          underflow_o <= 1'b1;
        end
      end
      if (drop && mem_rvalid_i) drop <= 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        mem_req_o <= 1'b0;
        pend <= 1'b1;
      end
      if (beat) begin
        pend <= 1'b0;
        mem_addr_o <= mem_addr_o + AW'(4);
        widx <= last ? '0 : widx + IW'(1);
      end
      case (state)
        FETCH: if (done) begin
          lines <= lines + 10'd1;
          fill_bank <= ~fill_bank;
          state <= (lines + 10'd1 == vlines) ? IDLE : full_nx[~fill_bank] ? WAIT : FETCH;
        end else if (!mem_req_o && !pend) begin
          if (!enable_i) state <= IDLE;
          else if (!drop) mem_req_o <= 1'b1;
        end
        WAIT: state <= !enable_i ? IDLE : full[fill_bank] ? WAIT : FETCH;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_line_buf.sv
// tb_vga_line_buf: randomized memory and display traffic checked against a frame-level reference model
module tb_vga_line_buf;
  logic clk = 1'b0, resetn, enable_i, frame_start_i, mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic data_req_i, underflow_o;
  logic [31:0] base_addr_i, mem_addr_o, mem_rdata_i;
  logic [9:0] hpixels_i, vlines_i;
  logic [11:0] data_o;
  int vectors = 0, miscompares = 0;
  int epoch = 0, f_h = 2, f_v = 1, dl = 0, r = 0;
  logic [31:0] f_base = '0;
  int words_filled = 0, k = 0, stall_lo = 0, stall_hi = 0, lat_lo = 0, lat_hi = 0;
  bit out_valid = 1'b0;
  always #5 clk = ~clk;
  vga_line_buf dut (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .base_addr_i(base_addr_i),
    .hpixels_i(hpixels_i), .vlines_i(vlines_i), .frame_start_i(frame_start_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .data_req_i(data_req_i),
    .data_o(data_o), .underflow_o(underflow_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [11:0] lo, hi;
    lo = a[11:0] ^ 12'h123;
    hi = a[11:0] * 12'd3 + 12'hABC;
    return {a[5:2], hi, a[9:6], lo};
  endfunction
  function automatic logic [11:0] exp_pix(input int line, input int px);
    logic [31:0] a, w;
    a = f_base + 32'(line) * 32'(f_h) * 32'd2 + 32'(px / 2) * 32'd4;
    w = mw(a);
    return (px % 2 == 1) ? w[27:16] : w[11:0];
  endfunction
  function automatic bit avail();
    return (words_filled / (f_h / 2)) > dl;
  endfunction
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  // memory: random grant stall and return latency, one beat in flight, address order checked per frame
  initial begin
    int stall, lat, mem_epoch, out_epoch, ret_epoch, seen_epoch;
    bit req_seen, ret_valid;
    logic [31:0] req_addr, out_addr;
    stall = 0; lat = 0; mem_epoch = 0; out_epoch = 0; ret_epoch = 0; seen_epoch = 0;
    req_seen = 0; ret_valid = 0; req_addr = '0; out_addr = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (epoch != mem_epoch) begin
        mem_epoch = epoch;
        k = 0;
        words_filled = 0;
      end
      if (ret_valid) begin
        if (ret_epoch == epoch) words_filled++;
        ret_valid = 0;
      end
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (out_valid) begin
        if (lat == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mw(out_addr);
          ret_valid = 1;
          ret_epoch = out_epoch;
          out_valid = 0;
        end else lat--;
      end
      if (mem_req_o) begin
        if (req_seen) check("addr_stable", mem_addr_o, req_addr);
        else begin
          req_seen = 1;
          req_addr = mem_addr_o;
          seen_epoch = epoch;
          stall = $urandom_range(stall_hi, stall_lo);
        end
        if (stall == 0) begin
          check("one_outstanding", 32'(out_valid), 0);
          check("addr", mem_addr_o, f_base + 32'(4 * k));
          k++;
          mem_gnt_i = 1'b1;
          out_valid = 1;
          out_addr = mem_addr_o;
          out_epoch = epoch;
          lat = $urandom_range(lat_hi, lat_lo);
          req_seen = 0;
        end else stall--;
      end else begin
        if (req_seen) check("req_held", 32'(epoch != seen_epoch), 1);
        req_seen = 0;
      end
    end
  end
  task automatic start_frame(input logic [31:0] base, input int h, input int v);
    base_addr_i = base;
    hpixels_i = 10'(h);
    vlines_i = 10'(v);
    frame_start_i = 1'b1;
    epoch++;
    f_base = base; f_h = h; f_v = v; dl = 0; r = 0;
    tick();
    frame_start_i = 1'b0;
  endtask
  task automatic step(input bit req);
    logic [11:0] e;
    e = '0;
    data_req_i = req;
    if (req) begin
      e = avail() ? exp_pix(dl, r) : 12'h000;
      r++;
      if (r == f_h) begin
        r = 0;
        dl++;
      end
    end
    tick();
    data_req_i = 1'b0;
    if (req) check("pix", 32'(data_o), 32'(e));
  endtask
  task automatic run_display();
    int n;
    n = 0;
    while (dl < f_v && n < 20000) begin
      step(avail() && $urandom_range(3) != 0);
      n++;
    end
    check("display_done", 32'(dl >= f_v), 1);
    repeat (4) tick();
    check("frame_beats", 32'(k), 32'(f_h / 2 * f_v));
    check("no_underflow", 32'(underflow_o), 0);
    check("idle_req", 32'(mem_req_o), 0);
  endtask
  initial begin
    int n;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    resetn = 1'b0; enable_i = 1'b1; frame_start_i = 1'b0; data_req_i = 1'b0;
    base_addr_i = '0; hpixels_i = 10'd2; vlines_i = 10'd1;
    repeat (3) tick();
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_uflow", 32'(underflow_o), 0);
    resetn = 1'b1;
    tick();
    // two 8-pixel lines from 0x1000 with a zero-wait memory
    start_frame(32'h1000, 8, 2);
    n = 0;
    while (words_filled < 8 && n < 200) begin tick(); n++; end
    repeat (5) tick();
    check("t1_beats", 32'(k), 8);
    check("t1_idle", 32'(mem_req_o), 0);
    step(1'b1);
    check("t2_first_pix", 32'(data_o), 32'h123);
    run_display();
    // pixel requested before the first line lands
    stall_lo = 2; stall_hi = 4; lat_lo = 1; lat_hi = 2;
    start_frame(32'h2000, 16, 2);
    step(1'b1);
    check("t3_uflow_set", 32'(underflow_o), 1);
    start_frame(32'h2000, 16, 2);
    check("t3_uflow_clr", 32'(underflow_o), 0);
    run_display();
    // long grant stall
    stall_lo = 5; stall_hi = 5; lat_lo = 0; lat_hi = 0;
    start_frame(32'h3000, 4, 1);
    run_display();
    // restart while a beat is in flight
    stall_lo = 0; stall_hi = 0; lat_lo = 4; lat_hi = 4;
    start_frame(32'h4000, 8, 1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("t5_in_flight", 32'(out_valid), 1);
    lat_lo = 0; lat_hi = 1;
    start_frame(32'h5000, 8, 1);
    run_display();
    // fetch disabled at frame start
    enable_i = 1'b0;
    start_frame(32'h5800, 8, 1);
    repeat (5) tick();
    check("disabled_req", 32'(mem_req_o), 0);
    enable_i = 1'b1;
    // reset mid-fetch
    stall_lo = 1; stall_hi = 2; lat_lo = 1; lat_hi = 2;
    start_frame(32'h6000, 32, 3);
    repeat (6) tick();
    resetn = 1'b0;
    epoch++;
    tick();
    check("t6_req", 32'(mem_req_o), 0);
    check("t6_addr", mem_addr_o, 0);
    check("t6_data", 32'(data_o), 0);
    check("t6_uflow", 32'(underflow_o), 0);
    resetn = 1'b1;
    n = 0;
    repeat (10) begin tick(); n += int'(mem_req_o); end
    check("t6_quiet", 32'(n), 0);
    // randomized frames including the line-length extremes
    for (int i = 0; i < 10; i++) begin
      stall_lo = 0; stall_hi = $urandom_range(3); lat_lo = 0; lat_hi = $urandom_range(2);
      if (i == 0) start_frame($urandom & 32'hFFFF_FFFC, 640, 2);
      else if (i == 1) start_frame($urandom & 32'hFFFF_FFFC, 2, 1);
      else start_frame($urandom & 32'hFFFF_FFFC, 2 * $urandom_range(20, 1), $urandom_range(4, 1));
      run_display();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
